// File: rtl/audio_output_pkg.sv
// Shared constants, power-down codes and FSM encoding for the audio DAC serializer.
package audio_output_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // DAC word layout: two don't-care zeros, power-down bits, then the sample.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd,
                                                         input logic [SAMPLE_BITS-1:0] smp);
        return {2'b00, pd, smp};
    endfunction

endpackage

// File: rtl/audio_output_sclk_tick_gen.sv
// Half-period timer for the DAC serial clock: emits one-cycle fall/rise strobes
// while enabled, starting from the high phase after each start pulse.
module sclk_tick_gen #(
    parameter int SCLK_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic en_i,
    output logic fall_o,
    output logic rise_o
);

    localparam int            CW     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          tick;

    assign tick   = en_i && (cnt_q == '0);
    assign fall_o = tick & phase_q;
    assign rise_o = tick & ~phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b1;
        end else if (start_i) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b1;
        end else if (en_i) begin
            if (tick) begin
                cnt_q   <= RELOAD;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_output.sv
// Streams 12-bit samples to a serial DAC as 16-bit frames through a one-deep holding register.
//   state    | meaning
//   ST_IDLE  | waiting for a held sample, dac_sync high
//   ST_SHIFT | frame on the wire, dac_sync low, sclk toggling
//   ST_GAP   | dac_sync high for GAP_CYCLES before the next frame
module audio_output
    import audio_output_pkg::*;
#(
    parameter int         SCLK_HALF  = 2,
    parameter int         GAP_CYCLES = 4,
    parameter logic [1:0] PD_MODE    = PD_NORMAL
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [SAMPLE_BITS-1:0] sample_i,
    input  logic                   sample_valid_i,
    output logic                   sample_ready_o,
    output logic                   dac_sync_o,
    output logic                   dac_sclk_o,
    output logic                   dac_din_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   overrun_o
);

    localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

    state_t                  state_q;
    logic                    hold_full_q, hold_full_d;
    logic [SAMPLE_BITS-1:0]  hold_q, hold_d;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [3:0]              bit_cnt_q;
    logic [GW-1:0]           gap_cnt_q;
    logic                    sync_q, sclk_q, din_q, busy_q, frame_done_q, overrun_q;
    logic                    accept, drain;
    logic                    sclk_fall, sclk_rise;

    assign accept      = sample_valid_i & ~hold_full_q;
    assign drain       = (state_q == ST_IDLE) & hold_full_q;
    assign hold_full_d = accept | (hold_full_q & ~drain);
    assign hold_d      = accept ? sample_i : hold_q;
    assign frame_word  = build_frame(PD_MODE, hold_q);

    sclk_tick_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_tick (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .start_i (drain),
        .en_i    (state_q == ST_SHIFT),
        .fall_o  (sclk_fall),
        .rise_o  (sclk_rise)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            hold_full_q  <= 1'b0;
            hold_q       <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            sync_q       <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            hold_full_q  <= hold_full_d;
            hold_q       <= hold_d;
            frame_done_q <= 1'b0;
            overrun_q    <= sample_valid_i & hold_full_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        shift_q   <= frame_word;
                        din_q     <= frame_word[FRAME_BITS-1];
                        bit_cnt_q <= 4'd15;
                        sync_q    <= 1'b0;
                        sclk_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_fall) begin
                        sclk_q <= 1'b0;
                    end else if (sclk_rise) begin
                        sclk_q <= 1'b1;
                        // The 16th rising edge closes the frame instead of presenting a bit.
                        if (bit_cnt_q == 4'd0) begin
                            sync_q       <= 1'b1;
                            din_q        <= 1'b0;
                            frame_done_q <= 1'b1;
                            gap_cnt_q    <= GAP_RELOAD;
                            state_q      <= ST_GAP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            din_q     <= shift_q[FRAME_BITS-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sync_q  <= 1'b1;
                    sclk_q  <= 1'b1;
                    din_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready_o = ~hold_full_q;
    assign dac_sync_o     = sync_q;
    assign dac_sclk_o     = sclk_q;
    assign dac_din_o      = din_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_audio_output.sv
// Drives three differently parameterised serializers with one stimulus stream and checks
// every output each cycle against a frame-timing model built from cycle arithmetic.
module tb_audio_output;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample = '0;
    logic        valid = 1'b0;

    logic [2:0] ready_w, sync_w, sclk_w, din_w, busy_w, fd_w, ovr_w;

    always #5 clk = ~clk;

    audio_output #(.SCLK_HALF(2), .GAP_CYCLES(4), .PD_MODE(2'b00)) dut0 (
        .clock_i(clk), .reset_i(rst), .sample_i(sample), .sample_valid_i(valid),
        .sample_ready_o(ready_w[0]), .dac_sync_o(sync_w[0]), .dac_sclk_o(sclk_w[0]),
        .dac_din_o(din_w[0]), .busy_o(busy_w[0]), .frame_done_o(fd_w[0]), .overrun_o(ovr_w[0]));

    audio_output #(.SCLK_HALF(1), .GAP_CYCLES(4), .PD_MODE(2'b00)) dut1 (
        .clock_i(clk), .reset_i(rst), .sample_i(sample), .sample_valid_i(valid),
        .sample_ready_o(ready_w[1]), .dac_sync_o(sync_w[1]), .dac_sclk_o(sclk_w[1]),
        .dac_din_o(din_w[1]), .busy_o(busy_w[1]), .frame_done_o(fd_w[1]), .overrun_o(ovr_w[1]));

    audio_output #(.SCLK_HALF(2), .GAP_CYCLES(4), .PD_MODE(2'b11)) dut2 (
        .clock_i(clk), .reset_i(rst), .sample_i(sample), .sample_valid_i(valid),
        .sample_ready_o(ready_w[2]), .dac_sync_o(sync_w[2]), .dac_sclk_o(sclk_w[2]),
        .dac_din_o(din_w[2]), .busy_o(busy_w[2]), .frame_done_o(fd_w[2]), .overrun_o(ovr_w[2]));

    int n_cmp = 0;
    int n_bad = 0;

    longint      e;
    longint      m_load [3];
    longint      m_free [3];
    bit          m_full [3];
    bit          m_ovr  [3];
    logic [11:0] m_held [3];
    logic [15:0] m_word [3];

    function automatic longint hp(input int i);
        return (i == 1) ? 64'd1 : 64'd2;
    endfunction

    function automatic longint gp(input int i);
        return (i >= 0) ? 64'd4 : 64'd4;
    endfunction

    function automatic logic [1:0] pdp(input int i);
        return (i == 2) ? 2'b11 : 2'b00;
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] cycle=%0d observed=%b expected=%b", tag, i, e, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0;
            m_ovr[i]  = 1'b0;
            m_load[i] = -1;
            m_free[i] = 0;
        end
    endtask

    // One rising edge as seen by the model: accept into an empty slot, drop into a full one,
    // and a held sample starts a frame once the previous frame plus gap plus idle cycle is over.
    task automatic model_edge(input bit v, input logic [11:0] s);
        bit pf, start;
        e++;
        for (int i = 0; i < 3; i++) begin
            pf       = m_full[i];
            m_ovr[i] = v && pf;
            start    = pf && (e >= m_free[i]);
            if (v && !pf) begin
                m_full[i] = 1'b1;
                m_held[i] = s;
            end
            if (start) begin
                m_word[i] = {2'b00, pdp(i), m_held[i]};
                m_full[i] = 1'b0;
                m_load[i] = e;
                m_free[i] = e + 32 * hp(i) + gp(i) + 1;
            end
        end
    endtask

    task automatic check_all();
        longint k;
        bit     shifting, bsy, fd;
        logic   x_sclk, x_din;
        int     idx;
        for (int i = 0; i < 3; i++) begin
            k        = e - m_load[i];
            shifting = (m_load[i] >= 0) && (k < 32 * hp(i));
            bsy      = (m_load[i] >= 0) && (k < 32 * hp(i) + gp(i));
            fd       = (m_load[i] >= 0) && (k == 32 * hp(i));
            x_sclk   = 1'b1;
            x_din    = 1'b0;
            if (shifting) begin
                x_sclk = ((k / hp(i)) % 2 == 0) ? 1'b1 : 1'b0;
                idx    = 15 - int'(k / (2 * hp(i)));
                x_din  = m_word[i][idx];
            end
            chk("ready", i, ready_w[i], ~m_full[i]);
            chk("sync",  i, sync_w[i],  ~shifting);
            chk("sclk",  i, sclk_w[i],  x_sclk);
            chk("din",   i, din_w[i],   x_din);
            chk("busy",  i, busy_w[i],  bsy);
            chk("done",  i, fd_w[i],    fd);
            chk("ovr",   i, ovr_w[i],   m_ovr[i]);
        end
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            chk("rst_sync",  i, sync_w[i],  1'b1);
            chk("rst_sclk",  i, sclk_w[i],  1'b1);
            chk("rst_din",   i, din_w[i],   1'b0);
            chk("rst_busy",  i, busy_w[i],  1'b0);
            chk("rst_done",  i, fd_w[i],    1'b0);
            chk("rst_ovr",   i, ovr_w[i],   1'b0);
            chk("rst_ready", i, ready_w[i], 1'b1);
        end
    endtask

    task automatic cyc(input bit v, input logic [11:0] s);
        valid  = v;
        sample = s;
        @(posedge clk);
        model_edge(v, s);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 12'h000);
    endtask

    // Asynchronous reset from mid-cycle; offers during reset must vanish.
    task automatic pulse_reset(input int ncyc);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_vals();
        for (int j = 0; j < ncyc; j++) begin
            valid  = 1'b1;
            sample = 12'($urandom);
            @(posedge clk);
            e++;
            @(negedge clk);
            check_reset_vals();
        end
        valid = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        e = 0;
        model_reset();
        @(negedge clk);
        check_reset_vals();
        pulse_reset(2);
        idle(3);

        // single frame 0xABC
        cyc(1'b1, 12'hABC);
        idle(75);

        // 0x000, one cycle for the drain, then 0xFFF; 0x555 arrives while 0xFFF is held
        cyc(1'b1, 12'h000);
        idle(1);
        cyc(1'b1, 12'hFFF);
        idle(10);
        cyc(1'b1, 12'h555);
        idle(160);

        // PD_HIZ instance frame for 0x001
        cyc(1'b1, 12'h001);
        idle(75);

        // reset just after the 7th falling sclk edge of the default instance
        cyc(1'b1, 12'h123);
        idle(27);
        pulse_reset(3);
        idle(20);

        // continuous valid
        for (int j = 0; j < 200; j++) cyc(1'b1, 12'h123);
        idle(80);

        // random traffic, sparse then dense
        for (int j = 0; j < 500; j++) cyc($urandom_range(0, 9) < 2, 12'($urandom));
        for (int j = 0; j < 300; j++) cyc($urandom_range(0, 9) < 7, 12'($urandom));
        idle(20);
        pulse_reset(1);
        for (int j = 0; j < 200; j++) cyc($urandom_range(0, 3) == 0, 12'($urandom));
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_output.md
AUDIO_OUTPUT -- requirements
Module: audio_output

Interface
REQ-001 Parameter SCLK_HALF, default 2, CLOCK cycles per dac_sclk half-period (>=1; 2 gives 25 MHz from 100 MHz).
REQ-002 Parameter GAP_CYCLES, default 4, CLOCK cycles dac_sync held high between frames (>=1).
REQ-003 Parameter PD_MODE, default 2'b00, DAC power-down bits sent in every frame (00 = normal operation).
REQ-004 CLOCK  in  1  system clock, 100 MHz, sole clock of the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sample  in  12  unsigned audio sample to play.
REQ-007 sample_valid  in  1  sample is offered this cycle.
REQ-008 sample_ready  out  1  holding register empty; a sample offered this cycle is accepted.
REQ-009 dac_sync  out  1  DAC frame select, active low.
REQ-010 dac_sclk  out  1  DAC serial clock; idles high.
REQ-011 dac_din  out  1  DAC serial data, MSB first.
REQ-012 busy  out  1  high while a frame or inter-frame gap is in progress.
REQ-013 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-014 overrun  out  1  one-cycle pulse when an offered sample is dropped.

Function
REQ-015 Transfer occurs on a rising CLOCK edge with sample_valid=1 and sample_ready=1; sample is copied into a one-deep holding register.
REQ-016 sample_ready = NOT holding-full, combinational from the register.
REQ-017 sample_valid=1 with sample_ready=0 drops the sample, leaves the holding register unchanged, and pulses overrun for one cycle.
REQ-018 FSM states: IDLE, SHIFT, GAP.
REQ-019 IDLE with holding full: next edge loads the 16-bit shift register with {2'b00, PD_MODE, held sample}, clears holding-full, drives dac_sync low, and enters SHIFT.
REQ-020 The same edge that drains the holding register may accept a new sample; holding-full then stays set.
REQ-021 Latency: a sample accepted into an empty block at edge N drives dac_sync low at edge N+1.
REQ-022 SHIFT: dac_sclk toggles every SCLK_HALF cycles, starting high; dac_din updates only on rising dac_sclk (and at load); the DAC samples on falling edges.
REQ-023 SHIFT lasts exactly 32*SCLK_HALF cycles (16 falling and 16 rising edges); dac_sclk ends high.
REQ-024 SHIFT to GAP: dac_sync goes high and frame_done pulses on the same edge.
REQ-025 GAP holds dac_sync high for exactly GAP_CYCLES cycles, then enters IDLE; back-to-back frames are therefore separated by GAP_CYCLES+1 cycles of dac_sync high.
REQ-026 busy = 1 in SHIFT and GAP, 0 in IDLE.
REQ-027 dac_din = 0 whenever dac_sync = 1.
REQ-028 The serial bit counter is 4 bits and the half-period counter is clog2(SCLK_HALF) bits; neither wraps inside a frame.

Reset
REQ-029 reset asserted at any time, including mid-frame, immediately forces: IDLE, dac_sync=1, dac_sclk=1, dac_din=0, busy=0, frame_done=0, overrun=0, holding-full=0 (sample_ready=1).
REQ-030 A partially shifted frame is abandoned without a frame_done pulse; samples offered while reset is high are discarded.

Structure
REQ-031 A shared package holds: FRAME_BITS=16, SAMPLE_BITS=12, PD codes (PD_NORMAL=00, PD_1K=01, PD_100K=10, PD_HIZ=11), and the FSM state encoding.
REQ-032 One sub-module, sclk_tick_gen, produces rise/fall strobes from SCLK_HALF; shift logic and FSM stay in audio_output.

Verification
REQ-033 After reset, offer 0xABC for one cycle (SCLK_HALF=2) -> dac_sync low 64 cycles; dac_din on falling edges = 0000_1010_1011_1100; one frame_done pulse.
REQ-034 Offer 0x000 then 0xFFF on consecutive cycles -> both accepted; two frames with exactly GAP_CYCLES+1=5 cycles dac_sync high between them.
REQ-035 Offer a third sample 0x555 during frame one while holding holds 0xFFF -> overrun pulses once; 0x555 never appears on dac_din.
REQ-036 Assert reset after the 7th falling edge -> dac_sync=1, dac_sclk=1, dac_din=0 immediately; no frame_done; after release, idle until the next sample_valid.
REQ-037 PD_MODE=2'b11, sample 0x001 -> bit stream 0011_0000_0000_0001.
REQ-038 SCLK_HALF=1 with continuous valid for 0x123 -> dac_sync low 32 cycles per frame; overrun pulses on every offer made while sample_ready=0.
